// File: rtl/dds_sweep_pkg.sv
// Shared state encoding and default bus widths for the DDS frequency-sweep sequencer.
package dds_sweep_pkg;

  localparam int FTW_W    = 32;
  localparam int STEP_W   = 16;
  localparam int SETTLE_W = 24;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    TRIG,
    WAIT,
    NEXT
  } state_e;

endpackage

// File: rtl/dds_sweep_timer.sv
// Loadable down-counter that saturates at zero; zero_o is decoded from the count register.
// Load takes priority over decrement, so a reload restarts the interval cleanly.
module dds_sweep_timer #(
  parameter int W = 24
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Steps the DDS tuning word over N points: load (valid/ready), settle, trigger, await meas_done.
// DDS_SWEEP_MEAS_TIMEOUT_EN adds a meas_done watchdog that aborts the sweep and sets timeout_flag.
module dds_sweep_ctrl #(
  parameter int FTW_W       = dds_sweep_pkg::FTW_W,
  parameter int STEP_W      = dds_sweep_pkg::STEP_W,
  parameter int SETTLE_W    = dds_sweep_pkg::SETTLE_W,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                start,
  input  logic                abort,
  input  logic [FTW_W-1:0]    cfg_ftw_start,
  input  logic [FTW_W-1:0]    cfg_ftw_step,
  input  logic [STEP_W-1:0]   cfg_num_points,
  input  logic [SETTLE_W-1:0] cfg_settle,
  output logic [FTW_W-1:0]    dds_ftw,
  output logic                dds_ftw_valid,
  input  logic                dds_ftw_ready,
  output logic                meas_trig,
  input  logic                meas_done,
  output logic [STEP_W-1:0]   step_idx,
  output logic                busy,
  output logic                sweep_done,
  output logic                sweep_aborted
`ifdef DDS_SWEEP_MEAS_TIMEOUT_EN
  ,
  output logic                timeout_flag
`endif
);

  import dds_sweep_pkg::*;

  state_e              state_q, state_d;
  logic [FTW_W-1:0]    ftw_q, ftw_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [FTW_W-1:0]    step_sz_q;
  logic [STEP_W-1:0]   points_q;
  logic [SETTLE_W-1:0] settle_q;
  logic                done_q, done_d;
  logic                abrt_q, abrt_d;
  logic                latch_cfg;
  logic                settle_load;
  logic                settle_zero;
  logic                timeout_hit;

  dds_sweep_timer #(.W(SETTLE_W)) u_settle (
    .clk_i  (ACLK),
    .rst_i  (ARESET),
    .load_i (settle_load),
    .val_i  (settle_q),
    .dec_i  (state_q == SETTLE),
    .zero_o (settle_zero)
  );

`ifdef DDS_SWEEP_MEAS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic to_zero;
  logic to_flag_q;

  // Loaded while in TRIG so the count reaches zero in the last permitted WAIT cycle.
  dds_sweep_timer #(.W(TO_W)) u_timeout (
    .clk_i  (ACLK),
    .rst_i  (ARESET),
    .load_i (state_q == TRIG),
    .val_i  (TO_W'(TIMEOUT_CYC - 1)),
    .dec_i  (state_q == WAIT),
    .zero_o (to_zero)
  );

  assign timeout_hit = (state_q == WAIT) && to_zero && !meas_done;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      to_flag_q <= 1'b0;
    end else if (start && (state_q == IDLE)) begin
      to_flag_q <= 1'b0;
    end else if (timeout_hit && !abort) begin
      to_flag_q <= 1'b1;
    end
  end

  assign timeout_flag = to_flag_q;
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ftw_d       = ftw_q;
    step_d      = step_q;
    done_d      = 1'b0;
    abrt_d      = 1'b0;
    latch_cfg   = 1'b0;
    settle_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_num_points != '0) begin
            latch_cfg = 1'b1;
            ftw_d     = cfg_ftw_start;
            step_d    = '0;
            state_d   = LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (dds_ftw_ready) begin
          settle_load = 1'b1;
          state_d     = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_zero) state_d = TRIG;
      end
      TRIG: state_d = WAIT;
      WAIT: begin
        if (meas_done) begin
          state_d = NEXT;
        end else if (timeout_hit) begin
          abrt_d  = 1'b1;
          state_d = IDLE;
        end
      end
      NEXT: begin
        if (step_q == (points_q - STEP_W'(1))) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          ftw_d   = ftw_q + step_sz_q;
          step_d  = step_q + STEP_W'(1);
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides whatever handshake or completion happened in the same cycle.
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      ftw_d       = ftw_q;
      step_d      = step_q;
      done_d      = 1'b0;
      abrt_d      = 1'b1;
      settle_load = 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      ftw_q     <= '0;
      step_q    <= '0;
      step_sz_q <= '0;
      points_q  <= '0;
      settle_q  <= '0;
      done_q    <= 1'b0;
      abrt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ftw_q   <= ftw_d;
      step_q  <= step_d;
      done_q  <= done_d;
      abrt_q  <= abrt_d;
      if (latch_cfg) begin
        step_sz_q <= cfg_ftw_step;
        points_q  <= cfg_num_points;
        settle_q  <= cfg_settle;
      end
    end
  end

  assign dds_ftw       = ftw_q;
  assign dds_ftw_valid = (state_q == LOAD);
  assign meas_trig     = (state_q == TRIG);
  assign step_idx      = step_q;
  assign busy          = (state_q != IDLE);
  assign sweep_done    = done_q;
  assign sweep_aborted = abrt_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: expected sweep events are queued at start, a monitor pops them.
module tb_dds_sweep_ctrl;

  localparam int TO_CYC   = 50;
  localparam int EV_LOAD  = 0;
  localparam int EV_TRIG  = 1;
  localparam int EV_DONE  = 2;
  localparam int EV_ABORT = 3;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_ftw_start = '0;
  logic [31:0] cfg_ftw_step = '0;
  logic [15:0] cfg_num_points = '0;
  logic [23:0] cfg_settle = '0;
  logic [31:0] dds_ftw;
  logic        dds_ftw_valid;
  logic        dds_ftw_ready = 1'b0;
  logic        meas_trig;
  logic        meas_done = 1'b0;
  logic [15:0] step_idx;
  logic        busy;
  logic        sweep_done;
  logic        sweep_aborted;
`ifdef DDS_SWEEP_MEAS_TIMEOUT_EN
  logic        timeout_flag;
`endif

  dds_sweep_ctrl #(
    .FTW_W(32), .STEP_W(16), .SETTLE_W(24), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .abort(abort),
    .cfg_ftw_start(cfg_ftw_start), .cfg_ftw_step(cfg_ftw_step),
    .cfg_num_points(cfg_num_points), .cfg_settle(cfg_settle),
    .dds_ftw(dds_ftw), .dds_ftw_valid(dds_ftw_valid), .dds_ftw_ready(dds_ftw_ready),
    .meas_trig(meas_trig), .meas_done(meas_done), .step_idx(step_idx),
    .busy(busy), .sweep_done(sweep_done), .sweep_aborted(sweep_aborted)
`ifdef DDS_SWEEP_MEAS_TIMEOUT_EN
    , .timeout_flag(timeout_flag)
`endif
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    int          kind;
    logic [31:0] ftw;
    logic [15:0] idx;
  } ev_t;

  ev_t         exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          hs_cyc = 0;
  int          last_trig_cyc = 0;
  int          last_abort_cyc = 0;
  int          n_abort_seen = 0;
  int          stall_cnt = 0;
  int          bp_cnt = 0;
  int          done_cnt = 0;
  int          rdy_mode = 0;
  bit          done_en = 1'b1;
  bit          abort_arm = 1'b0;
  bit          abort_fire = 1'b0;
  bit          idle_abort_req = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_ftw = '0;
  logic [23:0] cur_settle = '0;

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_ev(input int kind, input logic [31:0] ftw, input logic [15:0] idx);
    ev_t e;
    e.kind = kind;
    e.ftw  = ftw;
    e.idx  = idx;
    exp_q.push_back(e);
  endtask

  // Reference model: point i carries start + i*step (mod 2^32), then a trigger at that index.
  task automatic push_sweep(input logic [31:0] s, input logic [31:0] st, input int n, input bit full);
    for (int i = 0; i < n; i++) begin
      push_ev(EV_LOAD, s + st * i, 16'(i));
      push_ev(EV_TRIG, '0, 16'(i));
    end
    if (full) push_ev(EV_DONE, '0, '0);
  endtask

  task automatic expect_ev(input int kind, input logic [31:0] ftw, input logic [15:0] idx);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event_kind", 64'(kind), 64'hFF);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", 64'(kind), 64'(e.kind));
    if (kind == EV_LOAD) begin
      chk("load_ftw", 64'(ftw), 64'(e.ftw));
      chk("load_idx", 64'(idx), 64'(e.idx));
    end
    if (kind == EV_TRIG) chk("trig_idx", 64'(idx), 64'(e.idx));
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        chk("valid_hold", 64'(dds_ftw_valid), 64'd1);
        chk("ftw_hold", 64'(dds_ftw), 64'(prev_ftw));
      end
      prev_stall = dds_ftw_valid && !dds_ftw_ready;
      prev_ftw   = dds_ftw;
      if (prev_stall) stall_cnt++;
      if (dds_ftw_valid && dds_ftw_ready) begin
        expect_ev(EV_LOAD, dds_ftw, step_idx);
        hs_cyc = cyc;
      end
      if (meas_trig) begin
        expect_ev(EV_TRIG, '0, step_idx);
        chk("trig_latency", 64'(cyc - hs_cyc), 64'(cur_settle) + 64'd2);
        last_trig_cyc = cyc;
      end
      if (sweep_done) begin
        expect_ev(EV_DONE, '0, '0);
        chk("busy_at_done", 64'(busy), 64'd0);
      end
      if (sweep_aborted) begin
        expect_ev(EV_ABORT, '0, '0);
        chk("busy_at_abort", 64'(busy), 64'd0);
        chk("valid_at_abort", 64'(dds_ftw_valid), 64'd0);
        last_abort_cyc = cyc;
        n_abort_seen++;
      end
    end
  end

  // DDS ready, measurement engine and abort driver
  initial begin
    forever begin
      @(posedge ACLK);
      #1;
      abort     = 1'b0;
      meas_done = 1'b0;
      if (ARESET) begin
        done_cnt   = 0;
        abort_fire = 1'b0;
        continue;
      end
      case (rdy_mode)
        0: dds_ftw_ready = 1'b1;
        1: dds_ftw_ready = 1'($urandom_range(0, 1));
        default: begin
          if (dds_ftw_valid && step_idx == 16'd2 && bp_cnt < 10) begin
            dds_ftw_ready = 1'b0;
            bp_cnt++;
          end else begin
            dds_ftw_ready = 1'b1;
          end
        end
      endcase
      if (meas_trig) begin
        // A done in the trigger cycle must be ignored; the real one follows later.
        meas_done = done_en && ($urandom_range(0, 1) == 1);
        done_cnt  = $urandom_range(1, 5);
      end else if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0 && done_en) meas_done = 1'b1;
      end
      if (abort_fire) begin
        abort      = 1'b1;
        meas_done  = 1'b1;
        done_cnt   = 0;
        abort_fire = 1'b0;
        abort_arm  = 1'b0;
      end else if (abort_arm && meas_trig && step_idx == 16'd1) begin
        abort_fire = 1'b1;
      end
      if (idle_abort_req) begin
        abort          = 1'b1;
        idle_abort_req = 1'b0;
      end
    end
  end

  task automatic do_start(input logic [31:0] s, input logic [31:0] st, input logic [15:0] n,
                          input logic [23:0] se);
    @(posedge ACLK);
    #1;
    cfg_ftw_start  = s;
    cfg_ftw_step   = st;
    cfg_num_points = n;
    cfg_settle     = se;
    cur_settle     = se;
    start          = 1'b1;
    @(posedge ACLK);
    #1;
    start          = 1'b0;
    cfg_ftw_start  = $urandom;
    cfg_ftw_step   = $urandom;
    cfg_num_points = 16'($urandom);
    cfg_settle     = 24'($urandom_range(0, 40));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < budget) begin
      @(negedge ACLK);
      k++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge ACLK);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ftw"}, 64'(dds_ftw), 64'd0);
    chk({tag, "_valid"}, 64'(dds_ftw_valid), 64'd0);
    chk({tag, "_trig"}, 64'(meas_trig), 64'd0);
    chk({tag, "_idx"}, 64'(step_idx), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(sweep_done), 64'd0);
    chk({tag, "_aborted"}, 64'(sweep_aborted), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    logic [31:0] rs, rst;
    int rn;
    repeat (3) @(negedge ACLK);
    chk_all_zero("reset");
    @(posedge ACLK);
    #2;
    ARESET = 1'b0;

    // Basic sweep
    push_sweep(32'h1000, 32'h100, 4, 1'b1);
    do_start(32'h1000, 32'h100, 16'd4, 24'd3);
    chk("busy_after_start", 64'(busy), 64'd1);
    wait_idle("basic_complete", 400);

    // Backpressure on point 2
    rdy_mode  = 2;
    bp_cnt    = 0;
    stall_cnt = 0;
    push_sweep(32'h2000, 32'h10, 4, 1'b1);
    do_start(32'h2000, 32'h10, 16'd4, 24'd2);
    wait_idle("bp_complete", 400);
    chk("bp_stall_cycles", 64'(stall_cnt), 64'd10);
    rdy_mode = 0;

    // FTW wrap-around
    push_sweep(32'hFFFFFF00, 32'h100, 3, 1'b1);
    do_start(32'hFFFFFF00, 32'h100, 16'd3, 24'd1);
    wait_idle("wrap_complete", 400);

    // Abort in WAIT on point 1 with a coincident meas_done
    abort_arm = 1'b1;
    push_sweep(32'h5000, 32'h40, 2, 1'b0);
    push_ev(EV_ABORT, '0, '0);
    do_start(32'h5000, 32'h40, 16'd4, 24'd0);
    wait_idle("abort_complete", 400);
    chk("abort_fired", 64'(abort_arm), 64'd0);

    // Zero points
    push_ev(EV_DONE, '0, '0);
    do_start(32'h7000, 32'h1, 16'd0, 24'd2);
    chk("busy_zero_points", 64'(busy), 64'd0);
    wait_idle("zero_points_complete", 50);

    // Start while busy is ignored
    push_sweep(32'h9000, 32'h200, 3, 1'b1);
    do_start(32'h9000, 32'h200, 16'd3, 24'd2);
    repeat (2) @(posedge ACLK);
    #1;
    chk("busy_before_restart", 64'(busy), 64'd1);
    cfg_ftw_start  = 32'hDEAD0000;
    cfg_num_points = 16'd1;
    start          = 1'b1;
    @(posedge ACLK);
    #1;
    start = 1'b0;
    wait_idle("restart_ignored_complete", 400);

    // Abort while idle is ignored
    seen = n_abort_seen;
    idle_abort_req = 1'b1;
    repeat (5) @(negedge ACLK);
    chk("idle_abort_ignored", 64'(n_abort_seen), 64'(seen));

    // Reset in the middle of SETTLE
    push_sweep(32'hA000, 32'h1, 1, 1'b0);
    do_start(32'hA000, 32'h1, 16'd3, 24'd20);
    while (exp_q.size() > 1) @(negedge ACLK);
    repeat (3) @(posedge ACLK);
    #1;
    ARESET = 1'b1;
    #1;
    chk_all_zero("midreset");
    exp_q.delete();
    repeat (2) @(posedge ACLK);
    #2;
    ARESET = 1'b0;
    repeat (6) @(negedge ACLK);
    chk("midreset_no_events", 64'(exp_q.size()), 64'd0);

    // Randomized sweeps with random ready and done timing
    rdy_mode = 1;
    for (int t = 0; t < 8; t++) begin
      rs  = $urandom;
      rst = $urandom;
      rn  = $urandom_range(0, 5);
      push_sweep(rs, rst, rn, 1'b1);
      do_start(rs, rst, 16'(rn), 24'($urandom_range(0, 6)));
      wait_idle("random_complete", 1000);
    end
    rdy_mode = 0;

`ifdef DDS_SWEEP_MEAS_TIMEOUT_EN
    done_en = 1'b0;
    push_sweep(32'hB000, 32'h8, 1, 1'b0);
    push_ev(EV_ABORT, '0, '0);
    do_start(32'hB000, 32'h8, 16'd2, 24'd1);
    wait_idle("timeout_complete", 400);
    chk("timeout_delay", 64'(last_abort_cyc - last_trig_cyc), 64'(TO_CYC + 1));
    chk("timeout_flag_set", 64'(timeout_flag), 64'd1);
    done_en = 1'b1;
    push_sweep(32'hC000, 32'h8, 1, 1'b1);
    do_start(32'hC000, 32'h8, 16'd1, 24'd1);
    chk("timeout_flag_cleared", 64'(timeout_flag), 64'd0);
    wait_idle("post_timeout_complete", 400);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
- Frequency-sweep sequencer for the DDS core in the RLC measurement path.
- Steps the DDS frequency tuning word (FTW) from a start value by a fixed increment for N points.
- At each point: loads the FTW into the DDS, waits a programmable settle time, triggers one measurement, then waits for its completion.
- Sits between the AXI-Lite configuration registers and the DDS and measurement engines.

Parameters:
- FTW_W, 32, tuning word width.
- STEP_W, 16, width of point count and step index.
- SETTLE_W, 24, width of settle-cycle counter.
- TIMEOUT_CYC, 1000000, meas_done watchdog limit in cycles (used only with the optional feature).

Ports:
- ACLK  in  1  system clock.
- ARESET  in  1  asynchronous active-high reset.
- start  in  1  single-cycle pulse; begins a sweep when idle.
- abort  in  1  single-cycle pulse; terminates a sweep.
- cfg_ftw_start  in  FTW_W  first FTW.
- cfg_ftw_step  in  FTW_W  FTW increment per point.
- cfg_num_points  in  STEP_W  number of points; 0 means no sweep.
- cfg_settle  in  SETTLE_W  settle cycles after each FTW load.
- dds_ftw  out  FTW_W  FTW to the DDS.
- dds_ftw_valid  out  1  FTW valid.
- dds_ftw_ready  in  1  DDS accepts the FTW.
- meas_trig  out  1  one-cycle measurement trigger.
- meas_done  in  1  measurement complete pulse.
- step_idx  out  STEP_W  index of the current point.
- busy  out  1  high outside IDLE.
- sweep_done  out  1  one-cycle pulse on normal completion.
- sweep_aborted  out  1  one-cycle pulse on abort (or on timeout with the optional feature).

Behaviour:
- Reset values: all outputs 0; state IDLE. Reset mid-sweep returns to IDLE immediately; no done or aborted pulse is issued.
- Config inputs are sampled into internal registers on the start cycle. Later config changes do not affect a running sweep.
- State machine:
  - IDLE: on start with cfg_num_points!=0, latch config, set ftw=cfg_ftw_start, step_idx=0 -> LOAD. On start with cfg_num_points==0, pulse sweep_done next cycle and stay IDLE.
  - LOAD: dds_ftw_valid=1, dds_ftw stable. On valid&&ready -> SETTLE; valid drops the next cycle. Load counter with the latched settle value.
  - SETTLE: decrement the counter each cycle; at 0 -> TRIG. With settle=0, SETTLE lasts exactly one cycle.
  - TRIG: meas_trig=1 for one cycle -> WAIT.
  - WAIT: on meas_done -> NEXT. A meas_done arriving in the TRIG cycle is ignored.
  - NEXT: if step_idx==latched_points-1 -> IDLE with a sweep_done pulse. Otherwise ftw+=step (modulo 2^FTW_W, silent wrap), step_idx+=1 -> LOAD.
- Latency: dds_ftw_ready to meas_trig = settle+2 cycles.
- abort: honoured in any non-IDLE state. Next cycle goes to IDLE, pulses sweep_aborted, drops dds_ftw_valid. Abort takes priority over a simultaneous ready or meas_done. Abort in IDLE is ignored.
- start while busy: ignored.
- dds_ftw holds its last value after the sweep ends or is aborted.
- busy is registered: it goes high the cycle after the accepted start and low in the cycle IDLE is re-entered.

Optional Feature:
- Macro: DDS_SWEEP_MEAS_TIMEOUT_EN.
- Defined: a counter runs in WAIT. If meas_done is absent for TIMEOUT_CYC cycles, the block behaves exactly as on abort (sweep_aborted pulse, return to IDLE), and an extra output timeout_flag is set. timeout_flag is sticky and clears on the next accepted start.
- Undefined: WAIT waits indefinitely; no counter logic and no timeout_flag port.

Decomposition:
- Package dds_sweep_pkg holds:
  - the state enum (IDLE, LOAD, SETTLE, TRIG, WAIT, NEXT);
  - default widths FTW_W, STEP_W, SETTLE_W.
- One sub-module, dds_sweep_timer: a loadable down-counter with a zero flag, reused for settle and, when enabled, for the timeout.

Test Plan:
- Basic sweep: start=0x1000, step=0x100, points=4, settle=3, ready held high -> FTWs 0x1000, 0x1100, 0x1200, 0x1300; 4 meas_trig pulses, each 5 cycles after the handshake; sweep_done once; step_idx 0..3.
- Backpressure: ready held low 10 cycles on point 2 -> dds_ftw_valid stays high with FTW stable; SETTLE does not start until ready.
- Wrap-around: start=0xFFFFFF00, step=0x100, points=3 -> FTWs 0xFFFFFF00, 0x00000000, 0x00000100.
- Abort with meas_done in the same cycle during WAIT on point 1 -> sweep_aborted pulse, no sweep_done, no further meas_trig, busy low the next cycle.
- Edge cases: points=0 -> sweep_done only, no valid or trig. start while busy -> ignored. ARESET mid-SETTLE -> all outputs 0.
- With DDS_SWEEP_MEAS_TIMEOUT_EN and TIMEOUT_CYC=50: meas_done withheld -> sweep_aborted at cycle 50 of WAIT, timeout_flag=1; the next start clears it.
